// File: rtl/note_sequencer.sv
// Pattern sequencer feeding the synth voice: steps a small note RAM on a ms timebase, drives trig/osc_count.
// Optional feature macro: SEQ_TRANSPOSE_EN adds the transpose port (octave shift applied at load).
module note_sequencer #(
    parameter int unsigned STEPS    = 8,
    parameter int unsigned STEP_AW  = 3,
    parameter int unsigned PRESCALE = 20480,
    parameter int unsigned GAP_MS   = 26
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               run,
    input  logic               wr_en,
    input  logic [STEP_AW-1:0] wr_addr,
    input  logic [12:0]        wr_data,
    input  logic [9:0]         step_ms,
    input  logic [9:0]         gate_ms,
    input  logic [STEP_AW-1:0] last_step,
`ifdef SEQ_TRANSPOSE_EN
    input  logic [1:0]         transpose,
`endif
    output logic               trig,
    output logic [11:0]        osc_count,
    output logic [STEP_AW-1:0] step_idx,
    output logic               step_strobe
);

    localparam int unsigned PW = $clog2(PRESCALE);
    localparam int unsigned MW = 11;
    localparam logic [PW-1:0] PRE_LAST  = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_EARLY = PW'(PRESCALE - 2);
    localparam logic [MW-1:0] GAP       = MW'(GAP_MS);
    localparam logic [MW-1:0] MIN_STEP  = MW'(2 * GAP_MS);

    typedef enum logic [1:0] {IDLE, LOAD, GATE, LOW} state_t;

    state_t        state;
    logic [12:0]   pattern [STEPS];
    logic [PW-1:0] presc;
    logic [MW-1:0] ms_cnt;

    logic [12:0]   entry;
    logic [11:0]   note;
    logic [MW-1:0] s_eff, s_room, g_eff, ms_next;
    logic          silent, tick, tick_early, wrap;

    always_ff @(posedge clk) begin
        if (wr_en)
            pattern[wr_addr] <= wr_data;
    end

    always_comb begin
        entry = pattern[step_idx];
`ifdef SEQ_TRANSPOSE_EN
        note = entry[11:0] >> transpose;
`else
        note = entry[11:0];
`endif
        s_eff      = ({1'b0, step_ms} < MIN_STEP) ? MIN_STEP : {1'b0, step_ms};
        s_room     = s_eff - GAP;
        g_eff      = ({1'b0, gate_ms} < s_room) ? {1'b0, gate_ms} : s_room;
        silent     = entry[12] | (note == '0) | (g_eff == '0);
        tick       = (presc == PRE_LAST);
        tick_early = (presc == PRE_EARLY);
        ms_next    = ms_cnt + 1'b1;
        wrap       = (step_idx >= last_step);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            trig        <= 1'b0;
            osc_count   <= '0;
            step_idx    <= '0;
            step_strobe <= 1'b0;
            presc       <= '0;
            ms_cnt      <= '0;
        end else begin
            step_strobe <= 1'b0;
            if (!run) begin
                state    <= IDLE;
                trig     <= 1'b0;
                step_idx <= '0;
                presc    <= '0;
                ms_cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state <= LOAD;
                        presc <= '0;
                    end
                    LOAD: begin
                        osc_count   <= note;
                        step_strobe <= 1'b1;
                        ms_cnt      <= '0;
                        presc       <= '0;
                        if (silent) begin
                            state <= LOW;
                            trig  <= 1'b0;
                        end else begin
                            state <= GATE;
                            trig  <= 1'b1;
                        end
                    end
                    GATE: begin
                        presc <= tick ? '0 : presc + 1'b1;
                        if (tick) begin
                            ms_cnt <= ms_next;
                            if (ms_next >= g_eff) begin
                                state <= LOW;
                                trig  <= 1'b0;
                            end
                        end
                    end
                    LOW: begin
                        // The LOAD cycle takes the final prescaler slot of the outgoing step,
                        // so trig-high is exactly G ms and the step period exactly S ms.
                        if (tick_early && (ms_next >= s_eff)) begin
                            state    <= LOAD;
                            step_idx <= wrap ? '0 : step_idx + 1'b1;
                            presc    <= '0;
                        end else begin
                            presc <= tick ? '0 : presc + 1'b1;
                            if (tick)
                                ms_cnt <= ms_next;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer with PRESCALE=4, GAP_MS=2: table of step/gate settings plus
// hand-written sequences for rests, stop/restart, write-during-load, last_step change and reset.
module tb_note_sequencer;

    logic        clk = 1'b0;
    logic        rstn, run, wr_en;
    logic [2:0]  wr_addr;
    logic [12:0] wr_data;
    logic [9:0]  step_ms, gate_ms;
    logic [2:0]  last_step;
    logic        trig;
    logic [11:0] osc_count;
    logic [2:0]  step_idx;
    logic        step_strobe;
`ifdef SEQ_TRANSPOSE_EN
    logic [1:0]  transpose = 2'd0;
`endif

    int total = 0;
    int bad   = 0;
    logic [12:0] model [8];

    typedef struct {
        int sm;
        int gm;
        int exp_hi;
        int exp_lo;
    } vec_t;

    note_sequencer #(.STEPS(8), .STEP_AW(3), .PRESCALE(4), .GAP_MS(2)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .run        (run),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .step_ms    (step_ms),
        .gate_ms    (gate_ms),
        .last_step  (last_step),
`ifdef SEQ_TRANSPOSE_EN
        .transpose  (transpose),
`endif
        .trig       (trig),
        .osc_count  (osc_count),
        .step_idx   (step_idx),
        .step_strobe(step_strobe)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic write_entry(input int a, input logic [12:0] d);
        wr_en   = 1'b1;
        wr_addr = 3'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
        model[a] = d;
    endtask

    task automatic wait_strobe(input string name);
        int n = 0;
        while (!step_strobe && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(name, int'(step_strobe), 1);
    endtask

    // Called on the strobe cycle of a step; returns at the strobe cycle of the next step.
    task automatic step_meas(output int hi, output int lo, output int osc, output int idx);
        int n = 0;
        hi  = 0;
        lo  = 0;
        osc = int'(osc_count);
        idx = int'(step_idx);
        do begin
            if (trig) hi++;
            else      lo++;
            n++;
            @(negedge clk);
        end while (!step_strobe && n < 2000);
        check("step_bound", int'(step_strobe), 1);
    endtask

    vec_t vecs [7];
    int hi, lo, osc, idx;

    initial begin
        vecs[0] = '{sm: 8,  gm: 3,  exp_hi: 12, exp_lo: 20};
        vecs[1] = '{sm: 8,  gm: 20, exp_hi: 24, exp_lo: 8};
        vecs[2] = '{sm: 1,  gm: 3,  exp_hi: 8,  exp_lo: 8};
        vecs[3] = '{sm: 1,  gm: 0,  exp_hi: 0,  exp_lo: 16};
        vecs[4] = '{sm: 5,  gm: 1,  exp_hi: 4,  exp_lo: 16};
        vecs[5] = '{sm: 4,  gm: 2,  exp_hi: 8,  exp_lo: 8};
        vecs[6] = '{sm: 10, gm: 8,  exp_hi: 32, exp_lo: 8};

        rstn = 1'b0; run = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        step_ms = 10'd8; gate_ms = 10'd3; last_step = 3'd3;
        repeat (2) @(negedge clk);
        check("rst_trig", int'(trig), 0);
        check("rst_osc", int'(osc_count), 0);
        check("rst_idx", int'(step_idx), 0);
        check("rst_strobe", int'(step_strobe), 0);
        rstn = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 8; i++) begin
            write_entry(i, (i < 4) ? 13'((i + 1) * 100) : 13'd0);
            check("idle_trig", int'(trig), 0);
        end
        check("idle_osc", int'(osc_count), 0);
        check("idle_idx", int'(step_idx), 0);

        // start latency: LOAD in the first cycle, trig and strobe in the second
        run = 1'b1;
        @(negedge clk);
        check("lat_load_trig", int'(trig), 0);
        check("lat_load_strobe", int'(step_strobe), 0);
        @(negedge clk);
        check("lat_gate_trig", int'(trig), 1);
        check("lat_gate_strobe", int'(step_strobe), 1);
        check("lat_osc", int'(osc_count), 100);

        for (int k = 0; k < 5; k++) begin
            step_meas(hi, lo, osc, idx);
            check("basic_hi", hi, 12);
            check("basic_lo", lo, 20);
            check("basic_osc", osc, int'(model[k % 4][11:0]));
            check("basic_idx", idx, k % 4);
        end

        for (int v = 0; v < 7; v++) begin
            step_ms = 10'(vecs[v].sm);
            gate_ms = 10'(vecs[v].gm);
            step_meas(hi, lo, osc, idx);
            step_meas(hi, lo, osc, idx);
            check("tab_hi", hi, vecs[v].exp_hi);
            check("tab_lo", lo, vecs[v].exp_lo);
            check("tab_osc", osc, int'(model[idx][11:0]));
        end

        step_ms = 10'd8; gate_ms = 10'd3;
        step_meas(hi, lo, osc, idx);
        run = 1'b0;
        @(negedge clk);
        check("stop_trig", int'(trig), 0);
        check("stop_idx", int'(step_idx), 0);

        // rest on step 1
        write_entry(1, 13'h1000 | 13'd200);
        run = 1'b1;
        wait_strobe("rest_start");
        check("rest_s0_idx", int'(step_idx), 0);
        step_meas(hi, lo, osc, idx);
        check("rest_s0_hi", hi, 12);
        step_meas(hi, lo, osc, idx);
        check("rest_s1_hi", hi, 0);
        check("rest_s1_lo", lo, 32);
        check("rest_s1_osc", osc, 200);
        check("rest_s1_idx", idx, 1);

        // stop in the middle of the step-2 gate
        check("mid_gate_trig", int'(trig), 1);
        repeat (3) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        check("drop_trig", int'(trig), 0);
        check("drop_idx", int'(step_idx), 0);
        check("drop_osc_hold", int'(osc_count), 300);
        repeat (5) @(negedge clk);
        check("drop_strobe", int'(step_strobe), 0);
        write_entry(1, 13'd200);
        run = 1'b1;
        wait_strobe("rerun_start");
        check("rerun_idx", int'(step_idx), 0);
        check("rerun_osc", int'(osc_count), 100);

        // write entry 2 in the cycle it is loaded: old value plays now
        step_meas(hi, lo, osc, idx);
        repeat (31) @(negedge clk);
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 13'd333;
        @(negedge clk);
        wr_en = 1'b0;
        model[2] = 13'd333;
        check("coll_strobe", int'(step_strobe), 1);
        check("coll_idx", int'(step_idx), 2);
        check("coll_old", int'(osc_count), 300);
        for (int k = 0; k < 4; k++)
            step_meas(hi, lo, osc, idx);
        check("coll_new_idx", int'(step_idx), 2);
        check("coll_new", int'(osc_count), 333);

        // lower last_step below the current index
        step_meas(hi, lo, osc, idx);
        check("ls_at3", int'(step_idx), 3);
        last_step = 3'd1;
        step_meas(hi, lo, osc, idx);
        check("ls_wrap_idx", int'(step_idx), 0);
        check("ls_wrap_osc", int'(osc_count), 100);
        step_meas(hi, lo, osc, idx);
        check("ls_idx1", int'(step_idx), 1);
        step_meas(hi, lo, osc, idx);
        check("ls_wrap2", int'(step_idx), 0);

        // asynchronous reset while the gate is high
        check("pre_rst_trig", int'(trig), 1);
        rstn = 1'b0;
        #1;
        check("arst_trig", int'(trig), 0);
        check("arst_osc", int'(osc_count), 0);
        check("arst_idx", int'(step_idx), 0);
        check("arst_strobe", int'(step_strobe), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
